// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction queue.
//   ifq_entry_t : one queued fetch word together with its PC
//   FETCH_W     : fetch slots delivered per cycle
//   ISSUE_W     : entries presented to decode per cycle
//   min_u2      : unsigned minimum of two 2-bit values
package ifq_pkg;

    localparam int unsigned FETCH_W = 4;
    localparam int unsigned ISSUE_W = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ifq_entry_t;

    function automatic logic [1:0] min_u2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Bundle of signals between ifetch, the instruction queue and decode.
//   slave  : queue view (fetch bundle, flush and dec_take in; decode view and status out)
//   master : environment view (drives fetch/decode controls, observes queue outputs)
interface inst_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Fetch side
    logic [31:0]    in_inst0, in_inst1, in_inst2, in_inst3;
    logic [31:0]    in_pc0, in_pc1, in_pc2, in_pc3;
    logic           in_valid0, in_valid1, in_valid2, in_valid3;
    logic           flush;
    logic           fetch_stall;

    // Decode side
    logic [31:0]    out_inst0, out_inst1;
    logic [31:0]    out_pc0, out_pc1;
    logic           out_valid0, out_valid1;
    logic [1:0]     dec_take;

    // Status
    logic [PTR_W:0] count;
    logic           err_ovf;
    logic           err_unf;

    modport slave (
        input  in_inst0, in_inst1, in_inst2, in_inst3,
        input  in_pc0, in_pc1, in_pc2, in_pc3,
        input  in_valid0, in_valid1, in_valid2, in_valid3,
        input  flush, dec_take,
        output fetch_stall,
        output out_inst0, out_inst1, out_pc0, out_pc1, out_valid0, out_valid1,
        output count, err_ovf, err_unf
    );

    modport master (
        output in_inst0, in_inst1, in_inst2, in_inst3,
        output in_pc0, in_pc1, in_pc2, in_pc3,
        output in_valid0, in_valid1, in_valid2, in_valid3,
        output flush, dec_take,
        input  fetch_stall,
        input  out_inst0, out_inst1, out_pc0, out_pc1, out_valid0, out_valid1,
        input  count, err_ovf, err_unf
    );

endinterface

// File: rtl/inst_compact.sv
// Combinational compaction of a fetch bundle.
//   slot_i   : FETCH_W fetch entries in program order
//   valid_i  : per-slot valid mask (any pattern)
//   entry_o  : valid entries packed to the low indices, slot order preserved;
//              unused outputs are zero
//   n_in_o   : number of valid slots
// Each valid slot's destination index is the prefix count of valid slots before it.
module inst_compact
    import ifq_pkg::*;
(
    input  ifq_entry_t [FETCH_W-1:0] slot_i,
    input  logic       [FETCH_W-1:0] valid_i,
    output ifq_entry_t [FETCH_W-1:0] entry_o,
    output logic       [2:0]         n_in_o
);

    logic [2:0] pos [FETCH_W];

    // Exclusive prefix sum of the valid mask
    always_comb begin
        pos[0] = 3'd0;
        for (int i = 1; i < int'(FETCH_W); i++) begin
            pos[i] = pos[i-1] + {2'b00, valid_i[i-1]};
        end
    end

    always_comb begin
        n_in_o = pos[FETCH_W-1] + {2'b00, valid_i[FETCH_W-1]};
    end

    // Output j takes the one valid slot whose prefix count equals j
    always_comb begin
        entry_o = '0;
        for (int j = 0; j < int'(FETCH_W); j++) begin
            for (int i = 0; i < int'(FETCH_W); i++) begin
                if (valid_i[i] && (pos[i] == 3'(j))) begin
                    entry_o[j] = slot_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between ifetch and decode.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears pointers, occupancy and error flags
//   bus   : inst_queue_if slave port
//     in_*       up to four fetch words per cycle, compacted in slot order at tail
//     flush      drop queue contents and this cycle's input
//     fetch_stall raised while count > DEPTH-8, leaving room for two in-flight bundles
//     out_*      two oldest entries, show-ahead, combinational from storage
//     dec_take   entries consumed by decode this cycle (0..2)
//     count      occupancy; err_ovf / err_unf sticky error flags
module inst_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    inst_queue_if.slave  bus
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    // Wide enough for DEPTH - count + n_take without wrapping
    localparam int unsigned SPACE_W = PTR_W + 2;

    // Storage is deliberately not reset
    ifq_entry_t             mem_q [DEPTH];
    ifq_entry_t             mem_d [DEPTH];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_ovf_q, err_ovf_d;
    logic                   err_unf_q, err_unf_d;

    ifq_entry_t [FETCH_W-1:0] slots;
    logic       [FETCH_W-1:0] slot_valid;
    ifq_entry_t [FETCH_W-1:0] packed_entries;
    logic       [2:0]         n_in;

    logic [1:0]             avail;
    logic [1:0]             n_take;
    logic [SPACE_W-1:0]     space;
    logic [2:0]             n_acc;
    logic                   ovf;
    logic                   unf;
    logic [PTR_W-1:0]       head_p1;
    logic [PTR_W-1:0]       wr_idx;

    // ------------------------------------------------------------------
    // Fetch bundle compaction
    // ------------------------------------------------------------------
    always_comb begin
        slots[0].inst = bus.in_inst0;
        slots[0].pc   = bus.in_pc0;
        slots[1].inst = bus.in_inst1;
        slots[1].pc   = bus.in_pc1;
        slots[2].inst = bus.in_inst2;
        slots[2].pc   = bus.in_pc2;
        slots[3].inst = bus.in_inst3;
        slots[3].pc   = bus.in_pc3;
        slot_valid    = {bus.in_valid3, bus.in_valid2, bus.in_valid1, bus.in_valid0};
    end

    inst_compact u_compact (
        .slot_i  (slots),
        .valid_i (slot_valid),
        .entry_o (packed_entries),
        .n_in_o  (n_in)
    );

    // ------------------------------------------------------------------
    // Dequeue / enqueue amounts
    // ------------------------------------------------------------------
    always_comb begin
        if (count_q >= CNT_W'(ISSUE_W)) begin
            avail = 2'(ISSUE_W);
        end else begin
            avail = count_q[1:0];
        end
        n_take = min_u2(bus.dec_take, avail);
        unf    = (bus.dec_take > avail);

        // Slots freed by this cycle's dequeue are reusable at the same edge
        space = SPACE_W'(DEPTH) - {1'b0, count_q} + {{PTR_W{1'b0}}, n_take};
        if ({{(SPACE_W-3){1'b0}}, n_in} > space) begin
            ovf   = 1'b1;
            n_acc = space[2:0];   // space < n_in <= 4 here, so it fits; earliest slots kept
        end else begin
            ovf   = 1'b0;
            n_acc = n_in;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;

        if (bus.flush) begin
            // Flush wins over everything, including error detection this cycle
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d    = head_q + PTR_W'(n_take);
            tail_d    = tail_q + PTR_W'(n_acc);
            count_d   = count_q + CNT_W'(n_acc) - CNT_W'(n_take);
            err_ovf_d = err_ovf_q | ovf;
            err_unf_d = err_unf_q | unf;
        end
    end

    // Write-port demux: packed entry k lands at tail+k
    always_comb begin
        mem_d  = mem_q;
        wr_idx = tail_q;
        if (!bus.flush) begin
            for (int k = 0; k < int'(FETCH_W); k++) begin
                wr_idx = tail_q + PTR_W'(k);
                if (3'(k) < n_acc) begin
                    mem_d[wr_idx] = packed_entries[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        head_p1         = head_q + PTR_W'(1);
        bus.out_inst0   = mem_q[head_q].inst;
        bus.out_pc0     = mem_q[head_q].pc;
        bus.out_inst1   = mem_q[head_p1].inst;
        bus.out_pc1     = mem_q[head_p1].pc;
        bus.out_valid0  = (count_q >= CNT_W'(1));
        bus.out_valid1  = (count_q >= CNT_W'(2));
        bus.fetch_stall = (count_q > CNT_W'(DEPTH - 8));
        bus.count       = count_q;
        bus.err_ovf     = err_ovf_q;
        bus.err_unf     = err_unf_q;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue. Stimulus pushes expected PCs into exp_pc after each
// clock edge; a negedge monitor compares the DUT view against the scoreboard and pops
// what decode consumes. Directed spot checks use hand-computed constants.
module tb_inst_queue;

    localparam int unsigned DEPTH = 16;

    logic clock;
    logic reset;

    inst_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks;
    int          errors;
    logic [31:0] exp_pc [$];
    logic        exp_ovf;
    logic        exp_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic clear_inputs();
        bus.in_valid0 = 1'b0; bus.in_valid1 = 1'b0;
        bus.in_valid2 = 1'b0; bus.in_valid3 = 1'b0;
        bus.dec_take  = 2'd0;
        bus.flush     = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle, then updates the model after the edge.
    task automatic do_cycle(input logic [3:0] v, input logic [31:0] base,
                            input logic [1:0] take, input logic fl);
        logic [31:0] pcs [4];
        int sz, avail, ntake, space, cnt;
        logic unf;
        for (int i = 0; i < 4; i++) pcs[i] = base + 32'(4 * i);
        bus.in_pc0 = pcs[0]; bus.in_inst0 = inst_of(pcs[0]); bus.in_valid0 = v[0];
        bus.in_pc1 = pcs[1]; bus.in_inst1 = inst_of(pcs[1]); bus.in_valid1 = v[1];
        bus.in_pc2 = pcs[2]; bus.in_inst2 = inst_of(pcs[2]); bus.in_valid2 = v[2];
        bus.in_pc3 = pcs[3]; bus.in_inst3 = inst_of(pcs[3]); bus.in_valid3 = v[3];
        bus.dec_take = take;
        bus.flush    = fl;
        sz    = exp_pc.size();
        avail = (sz < 2) ? sz : 2;
        ntake = (int'(take) > avail) ? avail : int'(take);
        unf   = (int'(take) > avail);
        space = int'(DEPTH) - sz + ntake;
        @(posedge clock);
        #1;
        if (fl) begin
            exp_pc.delete();
        end else begin
            if (unf) exp_unf = 1'b1;
            cnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    if (cnt < space) exp_pc.push_back(pcs[i]);
                    else             exp_ovf = 1'b1;
                    cnt++;
                end
            end
        end
        clear_inputs();
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && exp_pc.size() > 0; g++) begin
            do_cycle(4'b0000, 32'h0, (exp_pc.size() >= 2) ? 2'd2 : 2'd1, 1'b0);
        end
        check("drain_empty", bus.count, 32'd0);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        exp_pc.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid0", 32'(bus.out_valid0), 32'd0);
        check("rst_valid1", 32'(bus.out_valid1), 32'd0);
        check("rst_stall", 32'(bus.fetch_stall), 32'd0);
        check("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
        check("rst_err_unf", 32'(bus.err_unf), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare the DUT view to the scoreboard, then retire what decode takes
    always @(negedge clock) begin
        int sz, n;
        sz = exp_pc.size();
        check("mon_count", 32'(bus.count), 32'(sz));
        check("mon_valid0", 32'(bus.out_valid0), 32'(sz >= 1));
        check("mon_valid1", 32'(bus.out_valid1), 32'(sz >= 2));
        check("mon_stall", 32'(bus.fetch_stall), 32'(sz > int'(DEPTH) - 8));
        check("mon_err_ovf", 32'(bus.err_ovf), 32'(exp_ovf));
        check("mon_err_unf", 32'(bus.err_unf), 32'(exp_unf));
        if (sz >= 1) begin
            check("mon_pc0", bus.out_pc0, exp_pc[0]);
            check("mon_inst0", bus.out_inst0, inst_of(exp_pc[0]));
        end
        if (sz >= 2) begin
            check("mon_pc1", bus.out_pc1, exp_pc[1]);
            check("mon_inst1", bus.out_inst1, inst_of(exp_pc[1]));
        end
        if (!reset && !bus.flush) begin
            n = int'(bus.dec_take);
            if (n > sz) n = sz;
            if (n > 2)  n = 2;
            for (int i = 0; i < n; i++) void'(exp_pc.pop_front());
        end
    end

    initial begin
        logic [3:0] mask;
        logic [1:0] take;
        checks  = 0;
        errors  = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        reset   = 1'b1;
        bus.in_pc0 = '0; bus.in_pc1 = '0; bus.in_pc2 = '0; bus.in_pc3 = '0;
        bus.in_inst0 = '0; bus.in_inst1 = '0; bus.in_inst2 = '0; bus.in_inst3 = '0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: reset mid-traffic at count=6
        do_cycle(4'b1111, 32'h1000, 2'd0, 1'b0);
        do_cycle(4'b0011, 32'h1010, 2'd0, 1'b0);
        check("t1_count6", 32'(bus.count), 32'd6);
        pulse_reset();

        // 2: full bundle into empty queue
        do_cycle(4'b1111, 32'h100, 2'd0, 1'b0);
        check("t2_count", 32'(bus.count), 32'd4);
        check("t2_pc0", bus.out_pc0, 32'h100);
        check("t2_pc1", bus.out_pc1, 32'h104);
        drain();

        // 3: sparse mask 0110
        do_cycle(4'b0110, 32'h200, 2'd0, 1'b0);
        check("t3_count", 32'(bus.count), 32'd2);
        check("t3_pc0", bus.out_pc0, 32'h204);
        check("t3_pc1", bus.out_pc1, 32'h208);
        drain();

        // 4: stall threshold and one more bundle
        do_cycle(4'b1111, 32'h300, 2'd0, 1'b0);
        do_cycle(4'b1111, 32'h310, 2'd0, 1'b0);
        do_cycle(4'b0001, 32'h320, 2'd0, 1'b0);
        check("t4_count9", 32'(bus.count), 32'd9);
        check("t4_stall", 32'(bus.fetch_stall), 32'd1);
        do_cycle(4'b1111, 32'h330, 2'd0, 1'b0);
        check("t4_count13", 32'(bus.count), 32'd13);
        check("t4_err_ovf", 32'(bus.err_ovf), 32'd0);
        check("t4_pc0", bus.out_pc0, 32'h300);
        drain();

        // 5: random masks across pointer wrap, honouring stall
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(0, 15));
            if (exp_pc.size() > int'(DEPTH) - 8) mask = 4'b0000;
            take = (exp_pc.size() >= 2) ? 2'd2 : 2'(exp_pc.size());
            do_cycle(mask, 32'h8000 + 32'(i * 16), take, 1'b0);
        end
        drain();
        check("t5_err_ovf", 32'(bus.err_ovf), 32'd0);
        check("t5_err_unf", 32'(bus.err_unf), 32'd0);

        // 6: flush beats input and dec_take
        do_cycle(4'b1111, 32'h400, 2'd0, 1'b0);
        do_cycle(4'b0001, 32'h410, 2'd0, 1'b0);
        check("t6_count5", 32'(bus.count), 32'd5);
        do_cycle(4'b1111, 32'h500, 2'd2, 1'b1);
        check("t6_count0", 32'(bus.count), 32'd0);
        check("t6_valid0", 32'(bus.out_valid0), 32'd0);
        do_cycle(4'b0001, 32'h600, 2'd0, 1'b0);
        check("t6_refill_pc0", bus.out_pc0, 32'h600);
        drain();

        // 7: underflow is sticky until reset
        do_cycle(4'b0001, 32'h700, 2'd0, 1'b0);
        check("t7_count1", 32'(bus.count), 32'd1);
        do_cycle(4'b0000, 32'h0, 2'd2, 1'b0);
        check("t7_count0", 32'(bus.count), 32'd0);
        check("t7_err_unf", 32'(bus.err_unf), 32'd1);
        repeat (3) do_cycle(4'b0000, 32'h0, 2'd0, 1'b0);
        check("t7_unf_sticky", 32'(bus.err_unf), 32'd1);
        pulse_reset();
        check("t7_unf_cleared", 32'(bus.err_unf), 32'd0);

        @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
